// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, opcode width and requester count.
package alu_pkg;

  localparam int ALU_OP_W = 4;
  localparam int N_REQ    = 2;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd7;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational execute-stage ALU. Shifts use only the low log2(W) bits of
// src_b, SLT is an unsigned compare, and unused opcodes produce zero.
module ALU
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]        src_a,
  input  logic [W-1:0]        src_b,
  input  logic [ALU_OP_W-1:0] op,
  output logic [W-1:0]        result,
  output logic                zero
);

  localparam int SHW = $clog2(W);

  logic [SHW-1:0] shamt;

  assign shamt = src_b[SHW-1:0];

  // Opcode decode; anything outside the defined set yields zero
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_XOR: result = src_a ^ src_b;
      ALU_SLL: result = src_a << shamt;
      ALU_SRL: result = src_a >> shamt;
      ALU_SLT: result = {{(W-1){1'b0}}, (src_a < src_b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, with a one-entry
// valid/ready response register that backpressures both requesters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [W-1:0]        req0_srcA,
  input  logic [W-1:0]        req0_srcB,
  input  logic [ALU_OP_W-1:0] req0_op,
  input  logic [W-1:0]        req1_srcA,
  input  logic [W-1:0]        req1_srcB,
  input  logic [ALU_OP_W-1:0] req1_op,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_id,
  output logic [W-1:0]        resp_result,
  output logic                resp_zero
);

  logic                prio_q, prio_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_id_q, resp_id_d;
  logic [W-1:0]        resp_result_q, resp_result_d;
  logic                resp_zero_q, resp_zero_d;

  logic [N_REQ-1:0]    grant;
  logic                can_accept;
  logic                accept;
  logic [W-1:0]        alu_a;
  logic [W-1:0]        alu_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [W-1:0]        alu_result;
  logic                alu_zero;

  // Pick the winner: a lone requester wins, a tie goes to the priority pointer
  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  // Handshake: accept only when the response slot is free or draining, never in reset
  always_comb begin
    can_accept = !resp_valid_q || resp_ready;
    req_ready  = (can_accept && !reset) ? grant : '0;
    accept     = |req_ready;
  end

  // Steer the winner's operands into the ALU; idle inputs are an ADD of zeros
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    if (grant[1]) begin
      alu_a  = req1_srcA;
      alu_b  = req1_srcB;
      alu_op = req1_op;
    end else if (grant[0]) begin
      alu_a  = req0_srcA;
      alu_b  = req0_srcB;
      alu_op = req0_op;
    end
  end

  ALU #(
    .W(W)
  ) u_alu (
    .src_a  (alu_a),
    .src_b  (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Next state: load on accept, drop valid on a plain drain, otherwise hold
  always_comb begin
    prio_d        = prio_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    if (accept) begin
      prio_d        = grant[0];
      resp_valid_d  = 1'b1;
      resp_id_d     = grant[1];
      resp_result_d = alu_result;
      resp_zero_d   = alu_zero;
    end else if (resp_ready) begin
      resp_valid_d  = 1'b0;
    end
  end

  // State registers with synchronous reset overriding everything else
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
    end else begin
      prio_q        <= prio_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by random traffic, with
// expected responses queued at acceptance and checked by a separate monitor.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          req_valid = '0;
  logic [1:0]          req_ready;
  logic [W-1:0]        req0_srcA = '0;
  logic [W-1:0]        req0_srcB = '0;
  logic [ALU_OP_W-1:0] req0_op = '0;
  logic [W-1:0]        req1_srcA = '0;
  logic [W-1:0]        req1_srcB = '0;
  logic [ALU_OP_W-1:0] req1_op = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic                resp_id;
  logic [W-1:0]        resp_result;
  logic                resp_zero;

  typedef struct {
    logic         id;
    logic [W-1:0] result;
    logic         zero;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  logic                pend_v[2];
  logic [W-1:0]        pend_a[2];
  logic [W-1:0]        pend_b[2];
  logic [ALU_OP_W-1:0] pend_op[2];

  logic model_full = 1'b0;
  logic next_first = 1'b0;

  alu_arbiter #(
    .W(W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_srcA   (req0_srcA),
    .req0_srcB   (req0_srcB),
    .req0_op     (req0_op),
    .req1_srcA   (req1_srcA),
    .req1_srcB   (req1_srcB),
    .req1_op     (req1_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_zero   (resp_zero)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Arithmetic reference for what the ALU should return
  function automatic logic [W-1:0] refAlu(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [ALU_OP_W-1:0] op);
    logic [W-1:0] sh;
    sh = b % W;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return (a < b) ? {{(W-1){1'b0}}, 1'b1} : '0;
      default: return '0;
    endcase
  endfunction

  task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setReq(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [ALU_OP_W-1:0] op);
    pend_v[idx]  = 1'b1;
    pend_a[idx]  = a;
    pend_b[idx]  = b;
    pend_op[idx] = op;
  endtask

  // Predict this cycle's grant, compare handshakes, and queue the accepted result
  task automatic checkOutput();
    logic [1:0] exp_ready;
    int         win;
    exp_t       e;
    logic [W-1:0] r;
    exp_ready = '0;
    win = -1;
    if (!reset && (!model_full || resp_ready)) begin
      if (pend_v[0] && pend_v[1]) win = int'(next_first);
      else if (pend_v[0])         win = 0;
      else if (pend_v[1])         win = 1;
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    checkVal("req_ready", W'(req_ready), W'(exp_ready));
    checkVal("resp_valid", W'(resp_valid), W'(model_full));
    if (reset) begin
      sb_q.delete();
      model_full = 1'b0;
      next_first = 1'b0;
    end else if (win >= 0) begin
      r = refAlu(pend_a[win], pend_b[win], pend_op[win]);
      e.id     = (win == 1);
      e.result = r;
      e.zero   = (r == '0);
      sb_q.push_back(e);
      model_full  = 1'b1;
      next_first  = (win == 0);
      pend_v[win] = 1'b0;
    end else if (resp_ready) begin
      model_full = 1'b0;
    end
  endtask

  // Drive one cycle of inputs after the edge, then check at the falling edge
  task automatic applyStimulus(input logic rst, input logic rdy);
    @(posedge clk);
    #1;
    reset      = rst;
    resp_ready = rdy;
    req_valid  = {pend_v[1], pend_v[0]};
    req0_srcA  = pend_a[0];
    req0_srcB  = pend_b[0];
    req0_op    = pend_op[0];
    req1_srcA  = pend_a[1];
    req1_srcB  = pend_b[1];
    req1_op    = pend_op[1];
    @(negedge clk);
    checkOutput();
  endtask

  // Monitor: every visible response must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_resp: got id=%0d result=%h with nothing expected",
                 resp_id, resp_result);
      end else begin
        checkVal("sb_id", W'(resp_id), W'(sb_q[0].id));
        checkVal("sb_result", resp_result, sb_q[0].result);
        checkVal("sb_zero", W'(resp_zero), W'(sb_q[0].zero));
        if (resp_ready) void'(sb_q.pop_front());
      end
    end
  end

  logic [W-1:0]        edge_a[3];
  logic [W-1:0]        edge_b[3];
  logic [ALU_OP_W-1:0] edge_op[3];
  logic [W-1:0]        edge_res[3];
  logic                edge_zero[3];

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend_v[i] = 1'b0; pend_a[i] = '0; pend_b[i] = '0; pend_op[i] = '0;
    end

    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkVal("reset_valid", W'(resp_valid), '0);
    checkVal("reset_id", W'(resp_id), '0);
    checkVal("reset_result", resp_result, '0);
    checkVal("reset_zero", W'(resp_zero), '0);

    setReq(0, 32'd5, 32'd7, ALU_ADD);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkVal("add_valid", W'(resp_valid), W'(1'b1));
    checkVal("add_id", W'(resp_id), '0);
    checkVal("add_result", resp_result, 32'd12);
    checkVal("add_zero", W'(resp_zero), '0);

    setReq(1, 32'd9, 32'd9, ALU_SUB);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkVal("sub_id", W'(resp_id), W'(1'b1));
    checkVal("sub_result", resp_result, '0);
    checkVal("sub_zero", W'(resp_zero), W'(1'b1));

    for (int i = 0; i < 4; i++) begin
      setReq(0, 32'hF0F0F0F0, 32'hFF00FF00, ALU_AND);
      setReq(1, 32'd1, 32'd31, ALU_SLL);
      applyStimulus(1'b0, 1'b1);
      checkVal("fair_grant", W'(req_ready), (i % 2 == 0) ? W'(2'b01) : W'(2'b10));
    end
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    applyStimulus(1'b0, 1'b1);

    setReq(0, 32'h1, 32'h2, ALU_OR);
    applyStimulus(1'b0, 1'b1);
    setReq(0, 32'h1, 32'h2, ALU_OR);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkVal("bp_ready", W'(req_ready), '0);
      checkVal("bp_hold", resp_result, 32'd3);
    end
    applyStimulus(1'b0, 1'b1);
    checkVal("drain_accept", W'(req_ready), W'(2'b01));
    applyStimulus(1'b0, 1'b1);
    checkVal("drain_valid", W'(resp_valid), W'(1'b1));

    edge_a[0] = 32'hFFFFFFFF; edge_b[0] = 32'd1;    edge_op[0] = ALU_SLT;
    edge_res[0] = '0;          edge_zero[0] = 1'b1;
    edge_a[1] = 32'h1234;     edge_b[1] = 32'h5678; edge_op[1] = 4'hA;
    edge_res[1] = '0;          edge_zero[1] = 1'b1;
    edge_a[2] = 32'h80000000; edge_b[2] = 32'h21;   edge_op[2] = ALU_SRL;
    edge_res[2] = 32'h40000000; edge_zero[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setReq(0, edge_a[i], edge_b[i], edge_op[i]);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkVal("edge_result", resp_result, edge_res[i]);
      checkVal("edge_zero", W'(resp_zero), W'(edge_zero[i]));
    end

    setReq(1, 32'd1, 32'd1, ALU_ADD);
    applyStimulus(1'b0, 1'b0);
    setReq(0, 32'd4, 32'd4, ALU_XOR);
    setReq(1, 32'd2, 32'd3, ALU_ADD);
    applyStimulus(1'b1, 1'b0);
    checkVal("rst_ready", W'(req_ready), '0);
    applyStimulus(1'b0, 1'b1);
    checkVal("rst_flush", W'(resp_valid), '0);
    checkVal("rst_first", W'(req_ready), W'(2'b01));
    pend_v[1] = 1'b0;
    applyStimulus(1'b0, 1'b1);

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
          logic [W-1:0] a;
          logic [W-1:0] b;
          a = $urandom;
          b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
          setReq(i, a, b, ALU_OP_W'($urandom_range(0, 15)));
        end
      end
      applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0);
    end

    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    repeat (4) applyStimulus(1'b0, 1'b1);
    checkVal("sb_empty", W'(sb_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
